// File: rtl/seq_detector_prog_if.sv
// Bus bundle for seq_detector_prog: runtime configuration, qualified serial
// input and detector results. With SEQ_DETECTOR_PROG_MASK_EN defined the
// bundle also carries the per-bit compare mask.
interface seq_detector_prog_if #(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = $clog2(SEQ_LEN + 1);

  logic               cfg_load;
  logic [SEQ_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
`ifdef SEQ_DETECTOR_PROG_MASK_EN
  logic [SEQ_LEN-1:0] cfg_mask;
`endif
  logic               din_valid;
  logic               din;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

`ifdef SEQ_DETECTOR_PROG_MASK_EN
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, din_valid, din,
    input  match, match_cnt, armed
  );
  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, din_valid, din,
    output match, match_cnt, armed
  );
`else
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  match, match_cnt, armed
  );
  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output match, match_cnt, armed
  );
`endif
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-sequence detector.
// Pattern (bit[len-1] received first), length and overlap mode are latched on
// cfg_load. match is a same-cycle Mealy pulse; match_cnt saturates; armed says
// the next valid bit can complete a match.
// Optional feature: SEQ_DETECTOR_PROG_MASK_EN adds a per-bit don't-care mask.
module seq_detector_prog #(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_prog_if.slave bus
);
  localparam int unsigned     LEN_W    = $clog2(SEQ_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SEQ_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [SEQ_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_armed;
`ifdef SEQ_DETECTOR_PROG_MASK_EN
  logic [SEQ_LEN-1:0] r_mask;
`endif

  logic [SEQ_LEN-1:0] w_window;
  logic [SEQ_LEN-1:0] w_cmp_mask;
  logic [LEN_W-1:0]   w_len_m1;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_bit_take;
  logic               w_match;

  assign w_window   = {r_hist, bus.din};
  assign w_len_m1   = r_len - LEN_W'(1);
  assign w_bit_take = bus.din_valid & ~bus.cfg_load;

  // Compare mask: only bits below the active length take part.
  always_comb begin
    w_cmp_mask = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      w_cmp_mask[i] = (LEN_W'(i) < r_len);
    end
`ifdef SEQ_DETECTOR_PROG_MASK_EN
    w_cmp_mask = w_cmp_mask & r_mask;
`endif
  end

  // Mealy match: window must hold len-1 bits since the last clear plus din.
  assign w_match = w_bit_take & (r_fill >= w_len_m1) &
                   (((w_window ^ r_pattern) & w_cmp_mask) == '0);

  // Clamp the loaded length into 1..SEQ_LEN.
  always_comb begin
    w_len_clamped = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      w_len_clamped = LEN_W'(1);
    end else if (bus.cfg_len > LEN_MAX) begin
      w_len_clamped = LEN_MAX;
    end
  end

  // Next fill: cleared by config load or a non-overlapping match, else saturating count.
  always_comb begin
    w_fill_next = r_fill;
    if (bus.cfg_load) begin
      w_fill_next = '0;
    end else if (bus.din_valid) begin
      if (w_match && !r_overlap) begin
        w_fill_next = '0;
      end else if (r_fill < FILL_MAX) begin
        w_fill_next = r_fill + LEN_W'(1);
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '1;
      r_len     <= LEN_MAX;
      r_overlap <= 1'b1;
`ifdef SEQ_DETECTOR_PROG_MASK_EN
      r_mask    <= '1;
`endif
    end else if (bus.cfg_load) begin
      r_pattern <= bus.cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= bus.cfg_overlap;
`ifdef SEQ_DETECTOR_PROG_MASK_EN
      r_mask    <= bus.cfg_mask;
`endif
    end
  end

  // Bit history, newest bit at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
    end else if (w_bit_take) begin
      r_hist <= w_window[SEQ_LEN-2:0];
    end
  end

  // Fill level and armed flag (next fill against the current length).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_fill  <= w_fill_next;
      r_armed <= (w_fill_next >= w_len_m1);
    end
  end

  // Saturating match counter, cleared on config load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (bus.cfg_load) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.match     = w_match;
  assign bus.match_cnt = r_cnt;
  assign bus.armed     = r_armed;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: hand-derived vector table,
// hand-written reset / saturation sequences, and randomized traffic checked
// against a queue-based model of the detection rules.
// SEQ_DETECTOR_PROG_MASK_EN builds drive the mask to all ones.
module tb_seq_detector_prog;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.SEQ_LEN(8), .CNT_W(8)) bus ();
  seq_detector_prog_if #(.SEQ_LEN(4), .CNT_W(2)) bus2 ();

  seq_detector_prog #(.SEQ_LEN(8), .CNT_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_detector_prog #(.SEQ_LEN(4), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                       input bit ovl, input bit v, input bit d);
    bus.cfg_load    = ld;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.din_valid   = v;
    bus.din         = d;
  endtask

  // Apply one cycle without checks.
  task automatic cyc(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                     input bit ovl, input bit v, input bit d);
    @(negedge clk);
    drive(ld, pat, len, ovl, v, d);
    @(posedge clk);
    #1;
  endtask

  // Vector table
  typedef struct {
    bit         ld;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ovl;
    bit         v;
    bit         d;
    bit         em;
    int         ec;
    bit         ea;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                              input bit ovl, input bit v, input bit d,
                              input bit em, input int ec, input bit ea);
    vec_t e;
    e.ld = ld; e.pat = pat; e.len = len; e.ovl = ovl; e.v = v; e.d = d;
    e.em = em; e.ec = ec; e.ea = ea;
    tbl.push_back(e);
  endfunction

  function automatic void bitv(input bit v, input bit d, input bit em, input int ec, input bit ea);
    add(1'b0, 8'h00, 4'd0, 1'b0, v, d, em, ec, ea);
  endfunction

  // Reference model: bits received since the last clear, oldest first.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_cnt;
  bit         m_armed;

  function automatic void model_reset();
    m_pat = 8'hFF; m_len = 8; m_ovl = 1'b1; m_q.delete(); m_cnt = 0; m_armed = 1'b0;
  endfunction

  function automatic bit model_match(input bit ld, input bit v, input bit d);
    int n;
    bit b;
    if (!v || ld) return 1'b0;
    n = m_q.size();
    if (n < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? d : m_q[n - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                                     input bit ovl, input bit v, input bit d, input bit mt);
    int old_len;
    old_len = m_len;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((int'(len) > 8) ? 8 : int'(len));
      m_ovl = ovl;
      m_q.delete();
      m_cnt = 0;
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() > 7) void'(m_q.pop_front());
      if (mt) begin
        if (!m_ovl) m_q.delete();
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_armed = (m_q.size() >= old_len - 1);
  endfunction

  initial begin
    bit         ld, v, d, ovl, em;
    logic [7:0] pat;
    logic [3:0] len;

    rst = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
`ifdef SEQ_DETECTOR_PROG_MASK_EN
    bus.cfg_mask  = '1;
    bus2.cfg_mask = '1;
`endif
    bus2.cfg_load = 1'b0; bus2.cfg_pattern = '0; bus2.cfg_len = '0;
    bus2.cfg_overlap = 1'b0; bus2.din_valid = 1'b0; bus2.din = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset match", bus.match, 0);
    chk("reset cnt", bus.match_cnt, 0);
    chk("reset armed", bus.armed, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    // Overlap: 1011 in 1,0,1,1,0,1,1
    add(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    bitv(1,1, 0,0,0); bitv(1,0, 0,0,0); bitv(1,1, 0,0,1); bitv(1,1, 1,1,1);
    bitv(1,0, 0,1,1); bitv(1,1, 0,1,1); bitv(1,1, 1,2,1);
    // Non-overlap: same stream
    add(1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    bitv(1,1, 0,0,0); bitv(1,0, 0,0,0); bitv(1,1, 0,0,1); bitv(1,1, 1,1,0);
    bitv(1,0, 0,1,0); bitv(1,1, 0,1,0); bitv(1,1, 0,1,1);
    // Valid gaps with toggling din
    add(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    bitv(1,1, 0,0,0); bitv(1,0, 0,0,0); bitv(1,1, 0,0,1);
    bitv(0,1, 0,0,1); bitv(0,0, 0,0,1); bitv(0,1, 0,0,1); bitv(0,0, 0,0,1); bitv(0,1, 0,0,1);
    bitv(1,1, 1,1,1);
    // Load beats a valid bit in the same cycle
    bitv(1,1, 0,1,1); bitv(1,0, 0,1,1); bitv(1,1, 0,1,1);
    add(1'b1, 8'h03, 4'd3, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    bitv(1,0, 0,0,0); bitv(1,1, 0,0,1); bitv(1,1, 1,1,1);
    // Length 0 clamps to 1, non-overlap still matches back to back
    add(1'b1, 8'h01, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    bitv(1,1, 1,1,1); bitv(1,1, 1,2,1); bitv(1,0, 0,2,1);
    // Length 15 clamps to 8
    add(1'b1, 8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    bitv(1,1, 0,0,0); bitv(1,0, 0,0,0); bitv(1,1, 0,0,0); bitv(1,0, 0,0,0);
    bitv(1,0, 0,0,0); bitv(1,1, 0,0,0); bitv(1,0, 0,0,1); bitv(1,1, 1,1,1);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].v, tbl[i].d);
      #1;
      chk($sformatf("tbl[%0d] match", i), bus.match, tbl[i].em);
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d] cnt", i), bus.match_cnt, tbl[i].ec);
      chk($sformatf("tbl[%0d] armed", i), bus.armed, tbl[i].ea);
    end

    // Async reset between edges
    cyc(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("rst pre cnt", bus.match_cnt, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst pre match", bus.match, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst async match", bus.match, 0);
    chk("rst async cnt", bus.match_cnt, 0);
    chk("rst async armed", bus.armed, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst release match", bus.match, 0);
    @(posedge clk);
    #1;
    chk("rst release cnt", bus.match_cnt, 0);
    chk("rst release armed", bus.armed, 0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    // Narrow counter saturation, len=1
    @(negedge clk);
    bus2.cfg_load = 1'b1; bus2.cfg_pattern = 4'b0001; bus2.cfg_len = 3'd1; bus2.cfg_overlap = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus2.cfg_load = 1'b0; bus2.din_valid = 1'b1; bus2.din = 1'b1;
      #1;
      chk($sformatf("sat[%0d] match", k), bus2.match, 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat[%0d] cnt", k), bus2.match_cnt, (k + 1 > 3) ? 3 : k + 1);
    end
    @(negedge clk);
    bus2.din_valid = 1'b0;

    // Randomized traffic against the model
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ld  = ($urandom_range(0, 39) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      ovl = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      drive(ld, pat, len, ovl, v, d);
      #1;
      em = model_match(ld, v, d);
      chk($sformatf("rnd[%0d] match", n), bus.match, em);
      model_step(ld, pat, len, ovl, v, d, em);
      @(posedge clk);
      #1;
      chk($sformatf("rnd[%0d] cnt", n), bus.match_cnt, m_cnt);
      chk($sformatf("rnd[%0d] armed", n), bus.armed, m_armed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
